// File: rtl/detect_burst_pkg.sv
// Shared types and helpers for the burst detector.
//   state_e        : detector FSM states
//   PageBytesLog   : log2 of the AXI page size that no burst may cross
//   next_beat_addr : address of the beat following a burst of len+1 beats
package detect_burst_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StEmit
   } state_e;

   localparam int unsigned PageBytesLog = 12;
   // Widest address next_beat_addr handles; callers zero-extend and truncate.
   localparam int unsigned MaxAddrWidth = 64;

   // base + (len+1) beats, wrapping modulo 2^MaxAddrWidth. len is widened first so
   // len == all-ones still yields the correct beat count.
   function automatic logic [MaxAddrWidth-1:0] next_beat_addr(
      input logic [MaxAddrWidth-1:0] base,
      input logic [31:0]             len,
      input int unsigned             beat_log
   );
      logic [MaxAddrWidth-1:0] beats;
      beats = MaxAddrWidth'(len) + MaxAddrWidth'(1);
      return base + (beats << beat_log);
   endfunction

endpackage

// File: rtl/detect_burst_bounded_if.sv
// FIFO-side signals of the burst detector.
//   master : detector side (pops the beat FIFO, pushes address/length FIFOs)
//   slave  : FIFO side
// Upstream beat FIFO : addr_dout, addr_empty_n, addr_read
// Address FIFO       : addr_din {len, base}, addr_full_n, addr_write
// Length FIFO        : burst_len_din, burst_len_full_n, burst_len_write
interface detect_burst_bounded_if #(
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned BurstLenWidth = 8
);

   logic [AddrWidth-1:0]               addr_dout;
   logic                               addr_empty_n;
   logic                               addr_read;
   logic [BurstLenWidth+AddrWidth-1:0] addr_din;
   logic                               addr_full_n;
   logic                               addr_write;
   logic [BurstLenWidth-1:0]           burst_len_din;
   logic                               burst_len_full_n;
   logic                               burst_len_write;

   modport master (
      input  addr_dout,
      input  addr_empty_n,
      input  addr_full_n,
      input  burst_len_full_n,
      output addr_read,
      output addr_din,
      output addr_write,
      output burst_len_din,
      output burst_len_write
   );

   modport slave (
      output addr_dout,
      output addr_empty_n,
      output addr_full_n,
      output burst_len_full_n,
      input  addr_read,
      input  addr_din,
      input  addr_write,
      input  burst_len_din,
      input  burst_len_write
   );

endinterface

// File: rtl/outstanding_counter.sv
// In-flight burst credit counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   inc_i           : a burst was emitted this cycle
//   dec_i           : a burst completed this cycle
//   count_o         : bursts emitted but not yet completed
//   credit_o        : count_o < MaxOutstanding (sampled before this cycle's dec_i)
//   err_underflow_o : sticky, set by a completion while count_o == 0
module outstanding_counter #(
   parameter int unsigned MaxOutstanding   = 16,
   parameter int unsigned OutstandingWidth = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        inc_i,
   input  logic                        dec_i,
   output logic [OutstandingWidth-1:0] count_o,
   output logic                        credit_o,
   output logic                        err_underflow_o
);

   logic [OutstandingWidth-1:0] count_q, count_d;
   logic                        err_q, err_d;

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (inc_i && !dec_i) begin
         count_d = count_q + OutstandingWidth'(1);
      end else if (dec_i && !inc_i) begin
         if (count_q == '0) begin
            err_d = 1'b1;
         end else begin
            count_d = count_q - OutstandingWidth'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count_o         = count_q;
   assign credit_o        = (32'(count_q) < MaxOutstanding);
   assign err_underflow_o = err_q;

endmodule

// File: rtl/detect_burst_bounded.sv
// Merges contiguous beat addresses into AXI INCR bursts, split at 4 KiB pages and at
// max_burst_len, and throttles emission by an in-flight credit count.
//   clk, rst_n    : clock, asynchronous active-low reset
//   max_wait_time : idle cycles tolerated before an open burst is closed
//   max_burst_len : burst length cap (beats-1)
//   fifo          : upstream beat FIFO and downstream address/length FIFOs
//   done          : one pulse per completed burst
//   outstanding   : in-flight burst count
//   err_underflow : sticky, completion seen with nothing in flight
// The fifo interface must be instantiated with the same AddrWidth/BurstLenWidth.
module detect_burst_bounded
   import detect_burst_pkg::*;
#(
   parameter int unsigned AddrWidth         = 64,
   parameter int unsigned DataWidthBytesLog = 6,
   parameter int unsigned WaitTimeWidth     = 4,
   parameter int unsigned BurstLenWidth     = 8,
   parameter int unsigned MaxOutstanding    = 16,
   parameter int unsigned OutstandingWidth  = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WaitTimeWidth-1:0]      max_wait_time,
   input  logic [BurstLenWidth-1:0]      max_burst_len,
   detect_burst_bounded_if.master        fifo,
   input  logic                          done,
   output logic [OutstandingWidth-1:0]   outstanding,
   output logic                          err_underflow
);

   state_e                   state_q, state_d;
   logic [AddrWidth-1:0]     base_q, base_d;
   logic [BurstLenWidth-1:0] len_q, len_d;
   logic [WaitTimeWidth-1:0] wait_q, wait_d;
   logic [AddrWidth-1:0]     next_addr;
   logic                     can_extend;
   logic                     credit;
   logic                     fire;
   logic                     rd_req;

   assign next_addr = AddrWidth'(next_beat_addr(MaxAddrWidth'(base_q), 32'(len_q),
                                                DataWidthBytesLog));

   // A page-aligned next beat always starts a new burst, even if contiguous.
   assign can_extend = (fifo.addr_dout == next_addr) &&
                       (len_q != max_burst_len) &&
                       (next_addr[PageBytesLog-1:0] != '0);

   // Both FIFOs are written together or not at all.
   assign fire = (state_q == StEmit) && fifo.addr_full_n && fifo.burst_len_full_n && credit;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      wait_d  = wait_q;
      rd_req  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fifo.addr_empty_n) begin
               rd_req  = 1'b1;
               base_d  = fifo.addr_dout;
               len_d   = '0;
               wait_d  = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (fifo.addr_empty_n) begin
               if (can_extend) begin
                  rd_req = 1'b1;
                  len_d  = len_q + BurstLenWidth'(1);
                  wait_d = '0;
               end else begin
                  // Blocking beat stays in the FIFO and opens the next burst.
                  state_d = StEmit;
               end
            end else if (wait_q == max_wait_time) begin
               state_d = StEmit;
            end else begin
               wait_d = wait_q + WaitTimeWidth'(1);
            end
         end
         StEmit: begin
            if (fire) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= '0;
         len_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         wait_q  <= wait_d;
      end
   end

   // Gated by rst_n so no pop is requested while the block is held in reset.
   assign fifo.addr_read       = rd_req & rst_n;
   assign fifo.addr_write      = fire;
   assign fifo.burst_len_write = fire;
   assign fifo.addr_din        = {len_q, base_q};
   assign fifo.burst_len_din   = len_q;

   outstanding_counter #(
      .MaxOutstanding   (MaxOutstanding),
      .OutstandingWidth (OutstandingWidth)
   ) u_outstanding_counter (
      .clk             (clk),
      .rst_n           (rst_n),
      .inc_i           (fire),
      .dec_i           (done),
      .count_o         (outstanding),
      .credit_o        (credit),
      .err_underflow_o (err_underflow)
   );

endmodule

// File: tb/tb_detect_burst_bounded.sv
module tb_detect_burst_bounded;

   localparam int unsigned AW   = 64;
   localparam int unsigned DWL  = 6;
   localparam int unsigned WTW  = 4;
   localparam int unsigned BLW  = 8;
   localparam int unsigned MAXO = 2;
   localparam int unsigned OW   = 5;

   typedef longint unsigned u64_t;
   typedef struct {
      u64_t base;
      int   len;
      int   cyc;
   } burst_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [WTW-1:0] max_wait_time;
   logic [BLW-1:0] max_burst_len;
   logic           done;
   logic [OW-1:0]  outstanding;
   logic           err_underflow;

   always #5 clk = ~clk;

   detect_burst_bounded_if #(.AddrWidth(AW), .BurstLenWidth(BLW)) fifo_if ();

   detect_burst_bounded #(
      .AddrWidth         (AW),
      .DataWidthBytesLog (DWL),
      .WaitTimeWidth     (WTW),
      .BurstLenWidth     (BLW),
      .MaxOutstanding    (MAXO),
      .OutstandingWidth  (OW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .max_wait_time (max_wait_time),
      .max_burst_len (max_burst_len),
      .fifo          (fifo_if),
      .done          (done),
      .outstanding   (outstanding),
      .err_underflow (err_underflow)
   );

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     last_pop = 0;
   u64_t   q[$];
   burst_t log_q[$];
   u64_t   last_addr = 0;

   // Reference model: phase 0 = no burst, 1 = collecting beats, 2 = burst closed.
   int     m_phase = 0;
   u64_t   m_base = 0;
   int     m_beats = 0;
   int     m_idle = 0;
   int     m_out = 0;
   bit     m_err = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_if.addr_empty_n = (q.size() > 0);
      fifo_if.addr_dout    = (q.size() > 0) ? q[0] : '0;
   endtask

   task automatic model_reset();
      m_phase = 0; m_base = 0; m_beats = 0; m_idle = 0; m_out = 0; m_err = 1'b0;
   endtask

   // One clock cycle: compare at the falling edge, advance the model at the rising edge.
   task automatic step();
      u64_t nxt;
      bit   ne, grow, e_read, e_fire;
      drive_fifo();
      @(negedge clk);
      ne   = (q.size() > 0);
      nxt  = m_base + (u64_t'(m_beats) << DWL);
      grow = 1'b0;
      if (ne) grow = (q[0] == nxt) && ((m_beats - 1) != int'(max_burst_len)) &&
                     ((nxt & 64'hFFF) != 0);
      e_read = (m_phase == 0 && ne) || (m_phase == 1 && grow);
      e_fire = (m_phase == 2) && fifo_if.addr_full_n && fifo_if.burst_len_full_n &&
               (m_out < int'(MAXO));
      check("addr_read", 128'(fifo_if.addr_read), 128'(e_read));
      check("addr_write", 128'(fifo_if.addr_write), 128'(e_fire));
      check("burst_len_write", 128'(fifo_if.burst_len_write), 128'(e_fire));
      if (e_fire) begin
         check("addr_din", 128'(fifo_if.addr_din), 128'({8'(m_beats - 1), 64'(m_base)}));
         check("burst_len_din", 128'(fifo_if.burst_len_din), 128'(m_beats - 1));
      end
      check("outstanding", 128'(outstanding), 128'(m_out));
      check("err_underflow", 128'(err_underflow), 128'(m_err));
      if (fifo_if.addr_write)
         log_q.push_back('{base: fifo_if.addr_din[63:0], len: int'(fifo_if.addr_din[71:64]),
                           cyc: cyc});
      if (e_read) last_pop = cyc;
      @(posedge clk);
      case (m_phase)
         0: if (ne) begin m_base = q[0]; m_beats = 1; m_idle = 0; m_phase = 1; end
         1: begin
            if (ne) begin
               if (grow) begin m_beats++; m_idle = 0; end
               else m_phase = 2;
            end else if (m_idle == int'(max_wait_time)) m_phase = 2;
            else m_idle++;
         end
         default: if (e_fire) m_phase = 0;
      endcase
      if (e_fire && !done) m_out++;
      else if (done && !e_fire) begin
         if (m_out == 0) m_err = 1'b1;
         else m_out--;
      end
      if (e_read) void'(q.pop_front());
      cyc++;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) begin
         if (m_out > 0) begin
            done = 1'b1; step(); done = 1'b0;
         end
      end
   endtask

   task automatic push_run(input u64_t base, input int n);
      for (int i = 0; i < n; i++) q.push_back(base + (u64_t'(i) << DWL));
   endtask

   task automatic check_burst(input string name, input int idx, input u64_t base, input int len);
      if (log_q.size() > idx) begin
         check({name, " base"}, 128'(log_q[idx].base), 128'(base));
         check({name, " len"}, 128'(log_q[idx].len), 128'(len));
      end else begin
         check({name, " present"}, 128'(log_q.size()), 128'(idx + 1));
      end
   endtask

   task automatic async_reset_check();
      #2 rst_n = 1'b0;
      #1;
      check("rst addr_read", 128'(fifo_if.addr_read), 128'(0));
      check("rst addr_write", 128'(fifo_if.addr_write), 128'(0));
      check("rst burst_len_write", 128'(fifo_if.burst_len_write), 128'(0));
      check("rst addr_din", 128'(fifo_if.addr_din), 128'(0));
      check("rst outstanding", 128'(outstanding), 128'(0));
      check("rst err_underflow", 128'(err_underflow), 128'(0));
      q.delete();
      model_reset();
      drive_fifo();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   int dc;

   initial begin
      max_wait_time = 4'd3;
      max_burst_len = 8'd255;
      done = 1'b0;
      fifo_if.addr_full_n = 1'b1;
      fifo_if.burst_len_full_n = 1'b1;
      drive_fifo();
      #1;
      check("reset addr_read", 128'(fifo_if.addr_read), 128'(0));
      check("reset addr_write", 128'(fifo_if.addr_write), 128'(0));
      check("reset outstanding", 128'(outstanding), 128'(0));
      check("reset err_underflow", 128'(err_underflow), 128'(0));
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b1;

      // Contiguous run of 8 beats.
      log_q.delete();
      push_run(64'h1000, 8);
      repeat (20) step();
      check("contig count", 128'(log_q.size()), 128'(1));
      check_burst("contig", 0, 64'h1000, 7);
      if (log_q.size() > 0) check("contig latency", 128'(log_q[0].cyc - last_pop), 128'(5));
      drain();

      // Length cap.
      log_q.delete();
      max_burst_len = 8'd15;
      push_run(64'h0, 20);
      repeat (40) step();
      check("cap count", 128'(log_q.size()), 128'(2));
      check_burst("cap0", 0, 64'h0, 15);
      check_burst("cap1", 1, 64'h400, 3);
      drain();

      // 4 KiB page split.
      log_q.delete();
      max_burst_len = 8'd255;
      q.push_back(64'hFC0);
      q.push_back(64'h1000);
      repeat (20) step();
      check("page count", 128'(log_q.size()), 128'(2));
      check_burst("page0", 0, 64'hFC0, 0);
      check_burst("page1", 1, 64'h1000, 0);
      drain();

      // Credit limit.
      log_q.delete();
      max_wait_time = 4'd0;
      q.push_back(64'h10000);
      q.push_back(64'h20000);
      q.push_back(64'h30000);
      repeat (20) step();
      check("credit held count", 128'(log_q.size()), 128'(2));
      check("credit held outstanding", 128'(outstanding), 128'(2));
      done = 1'b1; step(); done = 1'b0;
      dc = cyc - 1;
      step();
      check("credit release count", 128'(log_q.size()), 128'(3));
      if (log_q.size() > 2) check("credit release cycle", 128'(log_q[2].cyc), 128'(dc + 1));
      check("credit release outstanding", 128'(outstanding), 128'(2));
      drain();

      // Length FIFO backpressure.
      log_q.delete();
      fifo_if.burst_len_full_n = 1'b0;
      q.push_back(64'h40000);
      repeat (12) step();
      check("bp held count", 128'(log_q.size()), 128'(0));
      fifo_if.burst_len_full_n = 1'b1;
      repeat (3) step();
      check("bp release count", 128'(log_q.size()), 128'(1));
      check_burst("bp", 0, 64'h40000, 0);
      drain();

      // Underflow, then reset in the middle of an open burst.
      done = 1'b1; step(); done = 1'b0;
      check("underflow flag", 128'(err_underflow), 128'(1));
      check("underflow outstanding", 128'(outstanding), 128'(0));
      max_wait_time = 4'd15;
      push_run(64'h5000, 5);
      repeat (2) step();
      async_reset_check();
      log_q.delete();
      q.push_back(64'h5140);
      repeat (25) step();
      check("post-reset count", 128'(log_q.size()), 128'(1));
      check_burst("post-reset", 0, 64'h5140, 0);
      drain();

      // Randomized segments with fixed configuration per segment.
      for (int seg = 0; seg < 5; seg++) begin
         max_burst_len = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
         max_wait_time = 4'($urandom_range(0, 15));
         for (int i = 0; i < 600; i++) begin
            if (q.size() < 6 && $urandom_range(0, 99) < 60) begin
               if ($urandom_range(0, 99) < 80) begin
                  last_addr = last_addr + 64;
               end else begin
                  last_addr = {32'($urandom), 32'($urandom)} & ~64'h3F;
                  if ($urandom_range(0, 3) == 0) last_addr = (last_addr & ~64'hFFF) | 64'hF00;
               end
               q.push_back(last_addr);
            end
            fifo_if.addr_full_n      = ($urandom_range(0, 9) != 0);
            fifo_if.burst_len_full_n = ($urandom_range(0, 9) != 0);
            done = ((m_out > 0) && ($urandom_range(0, 99) < 30)) || ($urandom_range(0, 99) == 0);
            step();
         end
         done = 1'b0;
         fifo_if.addr_full_n = 1'b1;
         fifo_if.burst_len_full_n = 1'b1;
         for (int i = 0; i < 40; i++) begin
            done = (m_out > 0) && ($urandom_range(0, 1) == 1);
            step();
         end
         done = 1'b0;
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
